// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - per-register pending-write scoreboard gating ID issue
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int TOT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic             exe_allowin,
  input  logic             src1_valid,
  input  logic [4:0]       src1_addr,
  input  logic             src2_valid,
  input  logic [4:0]       src2_addr,
  input  logic             id_gr_we,
  input  logic [4:0]       id_dest,
  input  logic             wb_valid,
  input  logic             wb_gr_we,
  input  logic [4:0]       wb_dest,
  input  logic             flush,
  output logic             id_ready_go,
  output logic             id_fire,
  output logic [NREG-1:0]  busy_vec,
  output logic [TOT_W-1:0] inflight_cnt,
  output logic             err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [TOT_W-1:0] tot_q;
  logic             err_q;

  logic haz1, haz2, full;
  logic issue, retire, same_reg, underflow, issue_eff, retire_eff;

  // Hazards look only at registered counters: a retire this cycle is not bypassed.
  always_comb begin
    haz1 = src1_valid && (src1_addr != 5'd0) && (cnt[src1_addr] != '0);
    haz2 = src2_valid && (src2_addr != 5'd0) && (cnt[src2_addr] != '0);
    full = id_gr_we && (id_dest != 5'd0) && (cnt[id_dest] == CNT_MAX);
  end

  assign id_ready_go = !(haz1 || haz2 || full);
  assign id_fire     = id_valid && id_ready_go && exe_allowin;

  always_comb begin
    issue      = id_fire && id_gr_we && (id_dest != 5'd0);
    retire     = wb_valid && wb_gr_we && (wb_dest != 5'd0);
    same_reg   = issue && retire && (id_dest == wb_dest);
    underflow  = retire && !same_reg && (cnt[wb_dest] == '0);
    issue_eff  = issue && !same_reg;
    retire_eff = retire && !same_reg && !underflow;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (issue_eff && (int'(id_dest) == i))
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      if (retire_eff && (int'(wb_dest) == i))
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      tot_q <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      // Flush drops everything in flight but keeps the sticky error.
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      tot_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      if (issue_eff && !retire_eff)
        tot_q <= tot_q + TOT_W'(1);
      else if (retire_eff && !issue_eff)
        tot_q <= tot_q - TOT_W'(1);
      if (underflow)
        err_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_busy
    assign busy_vec[g] = (g != 0) && (cnt[g] != '0);
  end

  assign inflight_cnt  = tot_q;
  assign err_underflow = err_q;

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Register-hazard scheduler for the decode stage of the 5-stage in-order pipeline.
- Tracks every in-flight GPR write between issue (ID→EXE transfer) and retirement (WB regfile write).
- Drives ID's ready_go so an instruction does not issue while any source register it reads has a pending write.
- Replaces per-stage dest comparison with per-register pending counters; supports pipeline flush.

Parameters:
- NREG, 32, number of architectural GPRs (r0 hardwired zero, never tracked).
- CNT_W, 2, width of each per-register pending counter; max pending writes per register = 2^CNT_W-1.
- TOT_W, 3, width of total in-flight write count output.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- id_valid  in  1  ID holds a valid instruction.
- exe_allowin  in  1  EXE can accept this cycle.
- src1_valid  in  1  instruction reads raddr1.
- src1_addr  in  5  source register 1 (rj).
- src2_valid  in  1  instruction reads raddr2.
- src2_addr  in  5  source register 2 (rk or rd).
- id_gr_we  in  1  instruction writes a GPR.
- id_dest  in  5  destination GPR.
- wb_valid  in  1  WB retiring an instruction this cycle.
- wb_gr_we  in  1  retiring instruction writes the regfile.
- wb_dest  in  5  regfile write address.
- flush  in  1  discard all in-flight instructions (EXE/MEM/WB cancelled).
- id_ready_go  out  1  no hazard; ID may hand off.
- id_fire  out  1  id_valid & id_ready_go & exe_allowin.
- busy_vec  out  NREG  bit i = register i has ≥1 pending write.
- inflight_cnt  out  TOT_W  total pending writes across all registers.
- err_underflow  out  1  sticky: retire seen for a register with counter 0.

Behaviour:
- Reset: resetn is synchronous, active-low; clock clk. On reset, all counters=0, busy_vec=0, inflight_cnt=0, err_underflow=0. id_ready_go is then 1 and id_fire=id_valid&exe_allowin.
- Hazard (combinational from registered state only):
  - haz1 = src1_valid & src1_addr!=0 & cnt[src1_addr]!=0; haz2 likewise for src2.
  - full = id_gr_we & id_dest!=0 & cnt[id_dest]==max.
  - id_ready_go = ~(haz1|haz2|full).
- No same-cycle bypass: a WB retire of a source register in cycle N does not clear the hazard until cycle N+1, because the regfile write becomes visible only after the clock edge.
- Issue increment: id_fire & id_gr_we & id_dest!=0 → cnt[id_dest]+1 at the next edge.
- Retire decrement: wb_valid & wb_gr_we & wb_dest!=0 → cnt[wb_dest]-1.
- Same register issued and retired in the same cycle: counter unchanged.
- Underflow: a retire to a register with counter 0 leaves the counter at 0 and sets err_underflow until reset.
- Writes to r0 are never counted, and reads of r0 never stall.
- inflight_cnt = sum of all counters, maintained incrementally: +1 on counted issue, -1 on counted retire, both → unchanged. Registered, so it updates on the same edge as the counters.
- flush: all counters and inflight_cnt → 0 at the next edge. An issue or retire in the same cycle is ignored (flush wins). err_underflow is preserved.
- busy_vec[i] = |cnt[i], derived from registered counters; busy_vec[0]=0 always.
- A reset asserted mid-operation overrides flush, issue and retire.

Test Plan:
- Reset, then id_valid=1, src1=r5 valid, exe_allowin=1 → id_ready_go=1, id_fire=1; all outputs 0 the cycle after reset.
- Issue add r4 (we=1, dest=4) in cycle 0; cycle 1 src1=r4 → id_ready_go=0, busy_vec=0x10, inflight_cnt=1. WB retire r4 in cycle 3 → ready_go=0 in cycle 3, 1 in cycle 4.
- Issue three writers to r7 back-to-back with no retire → cnt[7]=3. A fourth with dest=7 and no sources → ready_go=0 (full). A retire r7 opens it the next cycle.
- Same cycle: issue dest=r9 and WB retire r9 with cnt[9]=1 → cnt[9] stays 1 and inflight_cnt is unchanged.
- cnt[3]=2, cnt[8]=1, assert flush together with an issue dest=r10 → next cycle busy_vec=0, inflight_cnt=0, cnt[10]=0.
- Dest=r0 issue, src=r0 reads, and a WB retire of r3 with cnt[3]=0 → no counter changes, ready_go=1, err_underflow=1 and held until resetn=0.
